// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: pipeline advance/freeze/flush control with a RAW scoreboard,
// memory-wait watchdog and saturating stall/flush counters.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_reg_write,
    input  logic [4:0]       id_rd,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_wren,
    output logic             if_id_wren,
    output logic             id_ex_wren,
    output logic             ex_mem_wren,
    output logic             mem_wb_wren,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;
    state_t state;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic ex_v, mem_v, wb_v, ex_rw, mem_rw, wb_rw;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic hit1, hit2, raw, miss, freeze, flush, stall;
    // WB is included: the register file writes at the edge without bypass
    assign hit1 = (ex_v & ex_rw & ex_rd == id_rs1) | (mem_v & mem_rw & mem_rd == id_rs1) |
                  (wb_v & wb_rw & wb_rd == id_rs1);
    assign hit2 = (ex_v & ex_rw & ex_rd == id_rs2) | (mem_v & mem_rw & mem_rd == id_rs2) |
                  (wb_v & wb_rw & wb_rd == id_rs2);
    assign raw = id_valid & ((id_uses_rs1 & id_rs1 != 5'd31 & hit1) |
                             (id_uses_rs2 & id_rs2 != 5'd31 & hit2));
    assign miss = mem_req & ~mem_ready;
    assign freeze = miss | state == HALT;
    assign flush = ~freeze & mem_branch_taken;
    assign stall = ~freeze & ~mem_branch_taken & raw;
    assign wait_nxt = wait_cnt + 1'b1;
    assign pc_wren = ~reset & ~freeze & ~stall;
    assign if_id_wren = pc_wren;
    assign id_ex_wren = ~reset & ~freeze;
    assign ex_mem_wren = id_ex_wren;
    assign mem_wb_wren = id_ex_wren;
    assign if_id_flush = reset | flush;
    assign ex_mem_flush = if_id_flush;
    assign id_ex_flush = reset | flush | stall;
    always_ff @(posedge clock) begin
        if (reset) begin
            {ex_v, mem_v, wb_v} <= '0;
            {ex_rw, mem_rw, wb_rw} <= '0;
            {ex_rd, mem_rd, wb_rd} <= '0;
            state <= RUN;
            wait_cnt <= '0;
            mem_error <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!freeze) begin
                {wb_v, wb_rd, wb_rw} <= {mem_v, mem_rd, mem_rw};
                {mem_v, mem_rd, mem_rw} <= {ex_v & ~flush, ex_rd, ex_rw};
                {ex_v, ex_rd, ex_rw} <= {id_valid & ~flush & ~stall, id_rd, id_reg_write};
            end
            if ((stall | freeze) & ~&stall_count) stall_count <= stall_count + 1'b1;
            if (flush & ~&flush_count) flush_count <= flush_count + 1'b1;
            case (state)
                RUN: if (miss) begin
                    state <= MEM_WAIT;
                    wait_cnt <= WW'(1);
                end
                MEM_WAIT: if (mem_ready) begin
                    state <= RUN;
                    wait_cnt <= '0;
                end else if (mem_req) begin
                    wait_cnt <= wait_nxt;
                    if (wait_nxt == WW'(MEM_TIMEOUT)) begin
                        state <= HALT;
                        mem_error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed checks of stall, flush, freeze, timeout and counters.
module tb_hazard_stall_controller;
    logic clock = 1'b0, reset = 1'b1;
    logic id_valid = 0, id_uses_rs1 = 0, id_uses_rs2 = 0, id_reg_write = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
    logic mem_branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_error;
    logic [3:0] stall_count, flush_count;
    int n_chk = 0, n_fail = 0;
    localparam logic [7:0] NORMAL = 8'b11111_000, STALL = 8'b00111_010;
    localparam logic [7:0] FLUSH = 8'b11111_111, FREEZE = 8'b00000_000, RST = 8'b00000_111;
    hazard_stall_controller #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
        .id_rd(id_rd), .mem_branch_taken(mem_branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .pc_wren(pc_wren), .if_id_wren(if_id_wren),
        .id_ex_wren(id_ex_wren), .ex_mem_wren(ex_mem_wren), .mem_wb_wren(mem_wb_wren),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count));
    always #5 clock = ~clock;
    wire [7:0] ctl = {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
                      if_id_flush, id_ex_flush, ex_mem_flush};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask
    task automatic settle();
        #1;
    endtask
    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                          input logic rw);
        id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw;
    endtask
    task automatic do_reset();
        reset = 1;
        set_id(0, 0, 0, 0, 0, 0, 0);
        mem_req = 0; mem_ready = 0; mem_branch_taken = 0;
        cyc();
        reset = 0;
    endtask
    initial begin
        #2;
        check("reset_ctl", 32'(ctl), 32'(RST));
        cyc();
        cyc();
        check("reset_stall_cnt", 32'(stall_count), 0);
        check("reset_flush_cnt", 32'(flush_count), 0);
        check("reset_err", 32'(mem_error), 0);
        reset = 0;
        // ADD X1 into EX, then SUB X2 reading X1 stalls 3 cycles
        set_id(1, 0, 0, 0, 0, 5'd1, 1);
        settle(); check("add_normal", 32'(ctl), 32'(NORMAL));
        cyc();
        set_id(1, 5'd1, 1, 0, 0, 5'd2, 1);
        for (int i = 0; i < 3; i++) begin
            settle(); check($sformatf("raw_stall%0d", i), 32'(ctl), 32'(STALL));
            cyc();
        end
        settle(); check("raw_resume", 32'(ctl), 32'(NORMAL));
        check("raw_stall_cnt", 32'(stall_count), 3);
        cyc();
        // X31 is never a hazard
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd31, 1);
        cyc();
        set_id(1, 5'd31, 1, 5'd31, 1, 5'd3, 0);
        settle(); check("x31_no_stall", 32'(ctl), 32'(NORMAL));
        // rs2 hazard only when rs2 is used
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd5, 1);
        cyc();
        set_id(1, 0, 0, 5'd5, 0, 5'd6, 0);
        settle(); check("rs2_unused", 32'(ctl), 32'(NORMAL));
        cyc();
        set_id(1, 0, 0, 5'd5, 1, 5'd7, 0);
        settle(); check("rs2_mem_stall", 32'(ctl), 32'(STALL));
        // taken branch beats pending RAW stall, squashes EX and MEM
        do_reset();
        set_id(1, 0, 0, 0, 0, 5'd1, 1);
        cyc();
        set_id(1, 0, 0, 0, 0, 5'd2, 1);
        cyc();
        set_id(1, 5'd2, 1, 0, 0, 5'd4, 1);
        mem_branch_taken = 1;
        settle(); check("branch_flush", 32'(ctl), 32'(FLUSH));
        cyc();
        mem_branch_taken = 0;
        check("branch_flush_cnt", 32'(flush_count), 1);
        check("branch_no_stall_cnt", 32'(stall_count), 0);
        settle(); check("branch_ex_squashed", 32'(ctl), 32'(NORMAL));
        set_id(1, 5'd1, 1, 0, 0, 5'd4, 1);
        settle(); check("branch_wb_kept", 32'(ctl), 32'(STALL));
        // 4-cycle memory wait
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            settle(); check($sformatf("mem_freeze%0d", i), 32'(ctl), 32'(FREEZE));
            cyc();
        end
        mem_ready = 1;
        settle(); check("mem_done", 32'(ctl), 32'(NORMAL));
        cyc();
        mem_req = 0; mem_ready = 0;
        check("mem_stall_cnt", 32'(stall_count), 4);
        check("mem_no_err", 32'(mem_error), 0);
        // timeout: 20 cycles not ready, HALT and counter saturation
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 20; i++) begin
            settle(); check($sformatf("to_freeze%0d", i), 32'(ctl), 32'(FREEZE));
            cyc();
            if (i == 14) check("to_err_before", 32'(mem_error), 0);
            if (i == 15) check("to_err_set", 32'(mem_error), 1);
        end
        check("sat_stall_cnt", 32'(stall_count), 15);
        mem_req = 0;
        settle(); check("halt_frozen", 32'(ctl), 32'(FREEZE));
        cyc();
        check("sat_hold", 32'(stall_count), 15);
        check("err_sticky", 32'(mem_error), 1);
        reset = 1;
        settle(); check("halt_reset_ctl", 32'(ctl), 32'(RST));
        cyc();
        reset = 0;
        check("halt_reset_err", 32'(mem_error), 0);
        check("halt_reset_cnt", 32'(stall_count), 0);
        settle(); check("halt_reset_run", 32'(ctl), 32'(NORMAL));
        // ready on the would-be timeout cycle completes the access
        do_reset();
        mem_req = 1; mem_ready = 0;
        repeat (14) cyc();
        mem_ready = 1;
        settle(); check("edge_ready", 32'(ctl), 32'(NORMAL));
        cyc();
        check("edge_no_err", 32'(mem_error), 0);
        mem_req = 0;
        settle(); check("edge_run", 32'(ctl), 32'(NORMAL));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
